// File: rtl/wave_trig_arbiter.sv
// rtl/wave_trig_arbiter.sv - round-robin trigger arbiter feeding the waveform generator
// Edge-captured request lines are queued as pending bits and issued one at a time.
module wave_trig_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1023,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  output logic             o_cmd_valid,
  output logic [ID_W-1:0]  o_cmd_id,
  input  logic             i_cmd_ready,
  input  logic             i_gen_done,
  output logic             o_busy,
  output logic [N_REQ-1:0] o_pending,
  output logic             o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_REQ-1:0]   r_prev;
  logic [N_REQ-1:0]   r_pending;
  logic [ID_W-1:0]    r_ptr;
  logic [CNT_W-1:0]   r_cnt;

  logic [N_REQ-1:0]   w_rise;
  logic [N_REQ-1:0]   w_clr;
  logic               w_sel_found;
  logic [ID_W-1:0]    w_sel_id;
  logic [ID_W-1:0]    w_cand;
  logic               w_valid_nxt;
  logic [ID_W-1:0]    w_id_nxt;
  logic               w_timeout_nxt;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  assign w_rise    = i_req & ~r_prev;
  assign o_pending = r_pending;

  // First pending line at or after the pointer, wrapping around.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_id    = '0;
    w_cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = ID_W'((int'(r_ptr) + i) % N_REQ);
      if (!w_sel_found && r_pending[w_cand]) begin
        w_sel_found = 1'b1;
        w_sel_id    = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_valid_nxt   = o_cmd_valid;
    w_id_nxt      = o_cmd_id;
    w_timeout_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_clr         = '0;
    case (r_state)
      S_IDLE: begin
        if (w_sel_found) begin
          w_state_nxt = S_ISSUE;
          w_valid_nxt = 1'b1;
          w_id_nxt    = w_sel_id;
        end
      end
      S_ISSUE: begin
        if (i_cmd_ready) begin
          w_clr       = N_REQ'(1) << o_cmd_id;
          w_ptr_nxt   = (o_cmd_id == ID_W'(N_REQ - 1)) ? '0 : o_cmd_id + ID_W'(1);
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (i_gen_done) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A new edge wins over the acceptance clear on the same line.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev      <= '0;
      r_pending   <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      o_cmd_valid <= 1'b0;
      o_cmd_id    <= '0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      r_prev      <= i_req;
      r_pending   <= (r_pending & ~w_clr) | w_rise;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      o_cmd_valid <= w_valid_nxt;
      o_cmd_id    <= w_id_nxt;
      o_busy      <= (w_state_nxt != S_IDLE);
      o_timeout   <= w_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_wave_trig_arbiter.sv
// tb/tb_wave_trig_arbiter.sv - directed self-checking bench for wave_trig_arbiter
module tb_wave_trig_arbiter;

  localparam int N_REQ = 4;
  localparam int TO    = 8;
  localparam int ID_W  = 2;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [N_REQ-1:0] i_req;
  logic             o_cmd_valid;
  logic [ID_W-1:0]  o_cmd_id;
  logic             i_cmd_ready;
  logic             i_gen_done;
  logic             o_busy;
  logic [N_REQ-1:0] o_pending;
  logic             o_timeout;

  int n_assert = 0;
  int n_fail   = 0;

  wave_trig_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TO)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_req(i_req),
    .o_cmd_valid(o_cmd_valid),
    .o_cmd_id(o_cmd_id),
    .i_cmd_ready(i_cmd_ready),
    .i_gen_done(i_gen_done),
    .o_busy(o_busy),
    .o_pending(o_pending),
    .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (o_cmd_valid !== 1'b1 && k < 20) begin
      cyc();
      k++;
    end
    chk(tag, 32'(o_cmd_valid), 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"},   32'(o_cmd_valid), 32'd0);
    chk({tag, "_id"},      32'(o_cmd_id),    32'd0);
    chk({tag, "_busy"},    32'(o_busy),      32'd0);
    chk({tag, "_pending"}, 32'(o_pending),   32'd0);
    chk({tag, "_timeout"}, 32'(o_timeout),   32'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_req = '0; i_cmd_ready = 1'b0; i_gen_done = 1'b0;
    cyc(); cyc();
    chk_reset_state("reset");
    i_rst = 1'b0;
    cyc();

    // All four lines at once from ptr=0: ids 0,1,2,3 in order.
    i_req = 4'b1111; i_cmd_ready = 1'b1;
    cyc();
    chk("t2_pending", 32'(o_pending), 32'hF);
    i_req = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      wait_valid($sformatf("t2_valid%0d", n));
      chk($sformatf("t2_id%0d", n), 32'(o_cmd_id), 32'(n));
      cyc();
      chk($sformatf("t2_acc_valid%0d", n), 32'(o_cmd_valid), 32'd0);
      chk($sformatf("t2_acc_pend%0d", n), 32'(o_pending), 32'((4'hF << (n + 1)) & 4'hF));
      cyc(); cyc();
      chk($sformatf("t2_wait_busy%0d", n), 32'(o_busy), 32'd1);
      i_gen_done = 1'b1;
      cyc();
      i_gen_done = 1'b0;
    end

    // Single line 1 edge with ready high.
    i_req = 4'b0010;
    cyc();
    chk("t1_pending", 32'(o_pending), 32'h2);
    chk("t1_valid_early", 32'(o_cmd_valid), 32'd0);
    i_req = 4'b0000;
    cyc();
    chk("t1_valid", 32'(o_cmd_valid), 32'd1);
    chk("t1_id", 32'(o_cmd_id), 32'd1);
    cyc();
    chk("t1_acc_valid", 32'(o_cmd_valid), 32'd0);
    chk("t1_acc_pend", 32'(o_pending), 32'd0);
    chk("t1_wait_busy", 32'(o_busy), 32'd1);
    i_gen_done = 1'b1;
    cyc();
    i_gen_done = 1'b0;
    chk("t1_idle_busy", 32'(o_busy), 32'd0);
    chk("t1_no_timeout", 32'(o_timeout), 32'd0);

    // ptr=2 with pending 1001: id 3 then wrap to id 0.
    i_req = 4'b1001; i_cmd_ready = 1'b0;
    cyc();
    chk("t3_pending", 32'(o_pending), 32'h9);
    i_req = 4'b0000;
    cyc();
    chk("t3_id3", 32'(o_cmd_id), 32'd3);
    i_cmd_ready = 1'b1;
    cyc();
    chk("t3_pend_after3", 32'(o_pending), 32'h1);
    i_gen_done = 1'b1;
    cyc();
    i_gen_done = 1'b0;
    cyc();
    chk("t3_valid0", 32'(o_cmd_valid), 32'd1);
    chk("t3_id0", 32'(o_cmd_id), 32'd0);
    cyc();
    chk("t4_acc_busy", 32'(o_busy), 32'd1);

    // No done: timeout after TO cycles in WAIT; a request arriving meanwhile is issued next.
    i_cmd_ready = 1'b0;
    for (int c = 1; c <= TO - 1; c++) begin
      if (c == 2) i_req = 4'b0100;
      if (c == 3) i_req = 4'b0000;
      cyc();
      chk($sformatf("t4_no_pulse%0d", c), 32'(o_timeout), 32'd0);
    end
    cyc();
    chk("t4_pulse", 32'(o_timeout), 32'd1);
    chk("t4_pulse_busy", 32'(o_busy), 32'd0);
    cyc();
    chk("t4_pulse_end", 32'(o_timeout), 32'd0);
    chk("t4_next_valid", 32'(o_cmd_valid), 32'd1);
    chk("t4_next_id", 32'(o_cmd_id), 32'd2);
    i_cmd_ready = 1'b1;
    cyc();
    i_cmd_ready = 1'b0;
    for (int c = 1; c <= TO - 1; c++) cyc();
    i_gen_done = 1'b1;
    cyc();
    i_gen_done = 1'b0;
    chk("t4_tie_no_pulse", 32'(o_timeout), 32'd0);
    chk("t4_tie_busy", 32'(o_busy), 32'd0);
    cyc();
    chk("t4_tie_no_pulse2", 32'(o_timeout), 32'd0);

    // Stall in ISSUE, then a new edge on the granted line during acceptance.
    i_req = 4'b0001;
    cyc();
    i_req = 4'b0000;
    cyc();
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk($sformatf("t5_hold%0d", c), {29'd0, o_cmd_valid, o_cmd_id}, {29'd0, 1'b1, 2'd0});
    end
    i_req = 4'b0001; i_cmd_ready = 1'b1;
    cyc();
    i_req = 4'b0000; i_cmd_ready = 1'b0;
    chk("t5_acc_valid", 32'(o_cmd_valid), 32'd0);
    chk("t5_set_wins", 32'(o_pending), 32'h1);
    i_gen_done = 1'b1;
    cyc();
    i_gen_done = 1'b0;
    cyc();
    chk("t5_reissue_valid", 32'(o_cmd_valid), 32'd1);
    chk("t5_reissue_id", 32'(o_cmd_id), 32'd0);
    i_cmd_ready = 1'b1;
    cyc();
    i_cmd_ready = 1'b0;

    // Reset during WAIT with pending work; line 1 held high through reset.
    i_req = 4'b0110;
    cyc();
    chk("t6_pending", 32'(o_pending), 32'h6);
    chk("t6_busy", 32'(o_busy), 32'd1);
    i_req = 4'b0010; i_rst = 1'b1;
    cyc();
    chk_reset_state("t6_rst");
    cyc();
    i_rst = 1'b0;
    cyc();
    chk("t6_one_edge", 32'(o_pending), 32'h2);
    cyc();
    chk("t6_valid", 32'(o_cmd_valid), 32'd1);
    chk("t6_id", 32'(o_cmd_id), 32'd1);
    i_cmd_ready = 1'b1;
    cyc();
    i_cmd_ready = 1'b0;
    cyc();
    chk("t6_held_no_req", 32'(o_pending), 32'd0);
    i_gen_done = 1'b1;
    cyc();
    i_gen_done = 1'b0;
    cyc();
    chk("t6_final_valid", 32'(o_cmd_valid), 32'd0);
    chk("t6_final_pending", 32'(o_pending), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
